// File: rtl/store_buffer.sv
// Posted-write store buffer between the MEM-stage control and the data
// memory. Stores are queued in a circular FIFO and retired one per cycle
// whenever the memory port is not claimed by a load miss. Loads forward from
// the youngest matching buffered store or pass straight through to memory.
module store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          resetn,
  input  logic          MemWrite,
  input  logic          MemRead,
  input  logic [AW-1:0] Addr_t,
  input  logic [DW-1:0] Wdata,
  output logic [DW-1:0] Rdata,
  output logic          Stall,
  output logic          Empty,
  output logic          mem_write,
  output logic          mem_read,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0]    addr_q [DEPTH];
  logic [DW-1:0]    data_q [DEPTH];
  logic [DEPTH-1:0] valid_q;
  logic [PW-1:0]    head_q;
  logic [PW-1:0]    tail_q;
  logic [CW-1:0]    count_q;

  logic          full;
  logic          empty;
  logic          load_req;
  logic          hit;
  logic          miss;
  logic [DW-1:0] fwd_data;

  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);
  assign load_req = MemRead & ~MemWrite;
  assign miss     = load_req & ~hit;
  assign Empty    = empty;

  // Word-address match, walking oldest to youngest so the youngest hit wins.
  always_comb begin
    hit      = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      logic [PW-1:0] idx;
      idx = head_q + PW'(k);
      if (valid_q[idx] && (addr_q[idx][AW-1:2] == Addr_t[AW-1:2])) begin
        hit      = 1'b1;
        fwd_data = data_q[idx];
      end
    end
  end

  // Memory-port arbitration and CPU-side response; everything quiet in reset.
  // NOTE: every output gets a default before any branch, so no latch can be inferred.
  always_comb begin
    mem_write = 1'b0;
    mem_read  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    Rdata     = '0;
    Stall     = 1'b0;
    if (resetn) begin
      if (full) begin
        mem_write = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end else if (miss) begin
        mem_read = 1'b1;
        mem_addr = Addr_t;
      end else if (!empty) begin
        mem_write = 1'b1;
        mem_addr  = addr_q[head_q];
        mem_wdata = data_q[head_q];
      end
      if (load_req) begin
        if (hit)        Rdata = fwd_data;
        else if (!full) Rdata = mem_rdata;
      end
      Stall = miss & full;
    end
  end

  // FIFO control: pointers, occupancy and per-entry valid bits.
  // NOTE: non-blocking assignments here; when full, push and pop hit the same
  // slot and the later (push) update to valid_q intentionally wins.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      if (mem_write) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PW'(1);
      end
      if (MemWrite) begin
        valid_q[tail_q] <= 1'b1;
        tail_q          <= tail_q + PW'(1);
      end
      count_q <= count_q + {{(CW-1){1'b0}}, MemWrite} - {{(CW-1){1'b0}}, mem_write};
    end
  end

  // Entry payload storage, written at the tail on every accepted store.
  // NOTE: payload is not reset; valid_q alone decides whether an entry is live.
  always_ff @(posedge clock) begin
    if (MemWrite) begin
      addr_q[tail_q] <= Addr_t;
      data_q[tail_q] <= Wdata;
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: a directed vector table, a reset
// sequence with buffered stores, and randomized traffic checked against a
// queue-based reference model with its own memory image.
module tb_store_buffer;

  localparam int DEPTH = 4;

  logic        clock;
  logic        resetn;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] Addr_t;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        Stall;
  logic        Empty;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  store_buffer #(.DEPTH(DEPTH), .AW(32), .DW(32)) dut (
    .clock     (clock),
    .resetn    (resetn),
    .MemWrite  (MemWrite),
    .MemRead   (MemRead),
    .Addr_t    (Addr_t),
    .Wdata     (Wdata),
    .Rdata     (Rdata),
    .Stall     (Stall),
    .Empty     (Empty),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Data memory: combinational read, written on the rising edge.
  logic [31:0] mem_arr [0:4095];
  logic        tb_we;
  logic [31:0] tb_wa;
  logic [31:0] tb_wd;
  assign mem_rdata = mem_arr[mem_addr[13:2]];

  always @(posedge clock) begin
    if (mem_write) mem_arr[mem_addr[13:2]] <= mem_wdata;
    if (tb_we)     mem_arr[tb_wa[13:2]]    <= tb_wd;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    MemWrite = mw;
    MemRead  = mr;
    Addr_t   = a;
    Wdata    = d;
  endtask

  task automatic poke(input logic [31:0] a, input logic [31:0] d);
    @(negedge clock);
    tb_we = 1'b1;
    tb_wa = a;
    tb_wd = d;
    @(negedge clock);
    tb_we = 1'b0;
  endtask

  // Directed vectors, applied back to back from an empty buffer.
  typedef struct {
    logic        mw, mr;
    logic [31:0] addr, wdata;
    logic        e_stall, e_mw, e_mr;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic        e_empty;
  } vec_t;

  vec_t vecs [13];

  // Reference model: FIFO of pending stores plus its own image of the random region.
  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } ent_t;

  ent_t        mq[$];
  logic [31:0] ref_mem [0:7];

  task automatic step(input logic mw, input logic mr, input logic [31:0] a, input logic [31:0] d);
    logic        hit, load, miss, full, e_mw, e_mr, e_stall;
    logic [31:0] hd, e_rdata, e_addr, e_wdata;
    hit = 1'b0;
    hd  = '0;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a[31:2] == a[31:2]) begin
        hit = 1'b1;
        hd  = mq[i].d;
        break;
      end
    end
    load    = mr && !mw;
    miss    = load && !hit;
    full    = (mq.size() == DEPTH);
    e_mw    = full || (!miss && mq.size() > 0);
    e_mr    = !full && miss;
    e_stall = miss && full;
    e_addr  = e_mw ? mq[0].a : a;
    e_wdata = e_mw ? mq[0].d : 32'h0;
    e_rdata = !load ? 32'h0 : hit ? hd : e_mr ? ref_mem[a[4:2]] : 32'h0;

    drive(mw, mr, a, d);
    #1;
    check("rnd_stall", {31'b0, Stall}, {31'b0, e_stall});
    check("rnd_mem_write", {31'b0, mem_write}, {31'b0, e_mw});
    check("rnd_mem_read", {31'b0, mem_read}, {31'b0, e_mr});
    check("rnd_rdata", Rdata, e_rdata);
    check("rnd_empty", {31'b0, Empty}, {31'b0, mq.size() == 0});
    if (e_mw || e_mr) check("rnd_mem_addr", mem_addr, e_addr);
    if (e_mw)         check("rnd_mem_wdata", mem_wdata, e_wdata);

    if (e_mw) begin
      ref_mem[mq[0].a[4:2]] = mq[0].d;
      void'(mq.pop_front());
    end
    if (mw) mq.push_back('{a: a, d: d});
  endtask

  initial begin
    resetn   = 1'b0;
    MemWrite = 1'b0;
    MemRead  = 1'b1;
    Addr_t   = 32'h2040;
    Wdata    = 32'h0;
    tb_we    = 1'b0;
    tb_wa    = '0;
    tb_wd    = '0;

    // Outputs held quiet during reset even with a load presented.
    #3;
    check("rst_empty", {31'b0, Empty}, 32'h1);
    check("rst_stall", {31'b0, Stall}, 32'h0);
    check("rst_mem_read", {31'b0, mem_read}, 32'h0);
    check("rst_mem_write", {31'b0, mem_write}, 32'h0);
    check("rst_rdata", Rdata, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);

    MemRead = 1'b0;
    @(negedge clock);
    resetn = 1'b1;
    poke(32'h2040, 32'hDEADBEEF);
    poke(32'h2100, 32'h12345678);

    //            mw  mr  addr         wdata        stall mw  mr  e_addr       e_wdata      e_rdata      empty
    vecs[0]  = '{1'b0,1'b0,32'h0,      32'h0,       1'b0,1'b0,1'b0,32'h0,      32'h0,       32'h0,       1'b1};
    vecs[1]  = '{1'b0,1'b1,32'h2040,   32'h0,       1'b0,1'b0,1'b1,32'h2040,   32'h0,       32'hDEADBEEF,1'b1};
    vecs[2]  = '{1'b1,1'b0,32'h2000,   32'h0000AAAA,1'b0,1'b0,1'b0,32'h0,      32'h0,       32'h0,       1'b1};
    vecs[3]  = '{1'b0,1'b1,32'h2003,   32'h0,       1'b0,1'b1,1'b0,32'h2000,   32'h0000AAAA,32'h0000AAAA,1'b0};
    vecs[4]  = '{1'b1,1'b0,32'h2004,   32'h11,      1'b0,1'b0,1'b0,32'h0,      32'h0,       32'h0,       1'b1};
    vecs[5]  = '{1'b0,1'b1,32'h2100,   32'h0,       1'b0,1'b0,1'b1,32'h2100,   32'h0,       32'h12345678,1'b0};
    vecs[6]  = '{1'b0,1'b1,32'h2004,   32'h0,       1'b0,1'b1,1'b0,32'h2004,   32'h11,      32'h11,      1'b0};
    vecs[7]  = '{1'b1,1'b0,32'h2008,   32'h22,      1'b0,1'b0,1'b0,32'h0,      32'h0,       32'h0,       1'b1};
    vecs[8]  = '{1'b1,1'b0,32'h2008,   32'h33,      1'b0,1'b1,1'b0,32'h2008,   32'h22,      32'h0,       1'b0};
    vecs[9]  = '{1'b0,1'b1,32'h200A,   32'h0,       1'b0,1'b1,1'b0,32'h2008,   32'h33,      32'h33,      1'b0};
    vecs[10] = '{1'b0,1'b1,32'h2008,   32'h0,       1'b0,1'b0,1'b1,32'h2008,   32'h0,       32'h33,      1'b1};
    vecs[11] = '{1'b1,1'b1,32'h200C,   32'h44,      1'b0,1'b0,1'b0,32'h0,      32'h0,       32'h0,       1'b1};
    vecs[12] = '{1'b0,1'b1,32'h200C,   32'h0,       1'b0,1'b1,1'b0,32'h200C,   32'h44,      32'h44,      1'b0};

    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].mw, vecs[i].mr, vecs[i].addr, vecs[i].wdata);
      #1;
      check($sformatf("vec%0d_stall", i), {31'b0, Stall}, {31'b0, vecs[i].e_stall});
      check($sformatf("vec%0d_mem_write", i), {31'b0, mem_write}, {31'b0, vecs[i].e_mw});
      check($sformatf("vec%0d_mem_read", i), {31'b0, mem_read}, {31'b0, vecs[i].e_mr});
      check($sformatf("vec%0d_rdata", i), Rdata, vecs[i].e_rdata);
      check($sformatf("vec%0d_empty", i), {31'b0, Empty}, {31'b0, vecs[i].e_empty});
      if (vecs[i].e_mw || vecs[i].e_mr)
        check($sformatf("vec%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      if (vecs[i].e_mw)
        check($sformatf("vec%0d_mem_wdata", i), mem_wdata, vecs[i].e_wdata);
    end

    // Reset with a store still buffered: it must be discarded, never written.
    drive(1'b1, 1'b0, 32'h2000, 32'h1);
    drive(1'b1, 1'b0, 32'h2004, 32'h2);
    drive(1'b1, 1'b0, 32'h2008, 32'h3);
    drive(1'b0, 1'b1, 32'h2000, 32'h0);
    #2;
    resetn = 1'b0;
    #1;
    check("midrst_empty", {31'b0, Empty}, 32'h1);
    check("midrst_mem_write", {31'b0, mem_write}, 32'h0);
    check("midrst_mem_read", {31'b0, mem_read}, 32'h0);
    check("midrst_rdata", Rdata, 32'h0);
    check("midrst_mem_wdata", mem_wdata, 32'h0);
    @(negedge clock);
    resetn = 1'b1;
    #1;
    check("postrst_mem_read", {31'b0, mem_read}, 32'h1);
    check("postrst_mem_addr", mem_addr, 32'h2000);
    check("postrst_rdata", Rdata, 32'h1);
    check("postrst_empty", {31'b0, Empty}, 32'h1);
    drive(1'b0, 1'b1, 32'h2008, 32'h0);
    #1;
    check("postrst_2008_mem_read", {31'b0, mem_read}, 32'h1);
    check("postrst_2008_rdata", Rdata, 32'h33);
    drive(1'b0, 1'b0, 32'h0, 32'h0);

    // Randomized traffic over an eight-word region seeded with known data.
    for (int i = 0; i < 8; i++) begin
      ref_mem[i] = 32'hC0DE_0000 + 32'(i);
      poke(32'h2200 + 32'(4 * i), ref_mem[i]);
    end
    mq.delete();
    for (int c = 0; c < 400; c++) begin
      int          op;
      logic [31:0] a;
      op = int'($urandom_range(0, 9));
      a  = 32'h2200 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(0, 3));
      if (op < 4)       step(1'b1, 1'b0, a, $urandom);
      else if (op < 8)  step(1'b0, 1'b1, a, 32'h0);
      else if (op == 8) step(1'b0, 1'b0, a, 32'h0);
      else              step(1'b1, 1'b1, a, $urandom);
    end
    for (int c = 0; c < DEPTH + 2; c++) step(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clock);
    for (int i = 0; i < 8; i++)
      check($sformatf("final_mem%0d", i), mem_arr[(32'h2200 >> 2) + i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
